// File: rtl/zbt_mem_arbiter.sv
// Single-port ZBT SRAM arbiter for the VGA, NTSC and processing requesters.
// Grants combinationally, issues one registered transaction per cycle and routes tagged read data back.
module zbt_mem_arbiter #(
  parameter int unsigned ADDR_W       = 19,
  parameter int unsigned DATA_W       = 36,
  parameter int unsigned RD_LATENCY   = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ack,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  input  logic              ntsc_req,
  input  logic [ADDR_W-1:0] ntsc_addr,
  input  logic [DATA_W-1:0] ntsc_wdata,
  output logic              ntsc_ack,
  input  logic              proc_req,
  input  logic              proc_we,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  output logic              proc_ack,
  output logic [DATA_W-1:0] proc_rdata,
  output logic              proc_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {RR_NTSC = 1'b0, RR_PROC = 1'b1} rr_t;

  rr_t              rr_ptr;
  logic [CNT_W-1:0] starve_cnt;
  logic             lower_pend, starve_slot, rr_ntsc, rr_proc;
  logic             gnt_vga, gnt_ntsc, gnt_proc, gnt_any, gnt_we;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;

  // Read tags: valid bit per stage, port bit 0 = VGA, 1 = proc
  logic [RD_LATENCY:0] vld_pipe;
  logic [RD_LATENCY:0] port_pipe;

  always_comb begin
    lower_pend  = ntsc_req | proc_req;
    starve_slot = lower_pend && (starve_cnt == CNT_W'(STARVE_LIMIT));
    rr_ntsc     = ntsc_req && (!proc_req || rr_ptr == RR_NTSC);
    rr_proc     = proc_req && !rr_ntsc;
    gnt_vga     = !reset && vga_req && !starve_slot;
    gnt_ntsc    = !reset && !gnt_vga && rr_ntsc;
    gnt_proc    = !reset && !gnt_vga && rr_proc;
    gnt_any     = gnt_vga | gnt_ntsc | gnt_proc;
    gnt_we      = gnt_ntsc | (gnt_proc & proc_we);
    gnt_addr    = vga_addr;
    gnt_wdata   = ntsc_wdata;
    if (gnt_ntsc) gnt_addr = ntsc_addr;
    if (gnt_proc) begin
      gnt_addr  = proc_addr;
      gnt_wdata = proc_wdata;
    end
  end

  assign vga_ack  = gnt_vga;
  assign ntsc_ack = gnt_ntsc;
  assign proc_ack = gnt_proc;

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr     <= RR_NTSC;
      starve_cnt <= '0;
    end else begin
      if (gnt_ntsc && rr_ptr == RR_NTSC) rr_ptr <= RR_PROC;
      if (gnt_proc && rr_ptr == RR_PROC) rr_ptr <= RR_NTSC;
      if (gnt_ntsc || gnt_proc || !lower_pend) starve_cnt <= '0;
      else if (gnt_vga)                        starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Issue stage: address/data hold when idle; write data only moves on writes
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= gnt_any;
      mem_we <= gnt_we;
      if (gnt_any) mem_addr  <= gnt_addr;
      if (gnt_we)  mem_wdata <= gnt_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe    <= '0;
      port_pipe   <= '0;
      vga_rvalid  <= 1'b0;
      proc_rvalid <= 1'b0;
      vga_rdata   <= '0;
      proc_rdata  <= '0;
    end else begin
      vld_pipe    <= {vld_pipe[RD_LATENCY-1:0], gnt_vga | (gnt_proc & ~proc_we)};
      port_pipe   <= {port_pipe[RD_LATENCY-1:0], gnt_proc};
      vga_rvalid  <= vld_pipe[RD_LATENCY] & ~port_pipe[RD_LATENCY];
      proc_rvalid <= vld_pipe[RD_LATENCY] &  port_pipe[RD_LATENCY];
      if (vld_pipe[RD_LATENCY] && !port_pipe[RD_LATENCY]) vga_rdata  <= mem_rdata;
      if (vld_pipe[RD_LATENCY] &&  port_pipe[RD_LATENCY]) proc_rdata <= mem_rdata;
    end
  end

endmodule
